fc_argmax_ctrl: RTL and testbench
=================================

# fc_argmax_ctrl

Sequencing controller for the FC output stage's argmax comparator. It collects the NUM_CLASSES class scores that the fully-connected layer streams out, one per beat, into a register buffer. It then pulses the comparator's reset, holds its enable until done, and presents the winning class index on a valid/ready output handshake. It sits between the FC accumulator output and the network result interface, and owns the comparator instance's control pins.

## Interface
- DATA_W, 16: width of one class score.
- NUM_CLASSES, 10: scores per frame; equals the comparator array depth.
- IDX_W, 4: class index width; 2^IDX_W must be at least NUM_CLASSES+1.
- TIMEOUT_CYCLES, 64: watchdog limit in RUN; used only with the macro.

Ports (clock and reset first):
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- score_valid  in  1  score beat valid.
- score_data  in  DATA_W  score value.
- score_last  in  1  marks the final beat of a frame.
- score_ready  out  1  buffer accepts a beat.
- cmp_arr  out  NUM_CLASSES*DATA_W  packed scores; score i occupies bits [DATA_W*i+DATA_W-1 : DATA_W*i].
- cmp_reset  out  1  active-high clear to the comparator.
- cmp_enable  out  1  comparator run enable.
- cmp_done  in  1  comparator finished.
- cmp_result  in  IDX_W  comparator winning index.
- class_valid  out  1  result valid.
- class_idx  out  IDX_W  winning class.
- class_ready  in  1  downstream accepts the result.
- busy  out  1  high in every state except LOAD.
- err  out  2  sticky error flags; bit0 = frame length, bit1 = timeout. Cleared only by reset.

## Operation
- A beat is accepted on a rising edge when score_valid and score_ready are both high.
- LOAD state:
  - score_ready=1.
  - Each accepted beat writes buf[cnt] and increments cnt.
  - On the beat where cnt==NUM_CLASSES-1, go to CLR and set cnt=0. If score_last is low on that beat, set err[0] and proceed anyway.
  - If score_last arrives on a beat where cnt<NUM_CLASSES-1: set err[0], discard the frame, set cnt=0, stay in LOAD. The buffer contents are don't-care.
- CLR state: lasts exactly one cycle; cmp_reset=1 and cmp_enable=0. Then go to RUN.
- RUN state: cmp_enable=1. When cmp_done is sampled high, register cmp_result into class_idx and go to OUT.
- OUT state:
  - class_valid=1 and cmp_enable=0.
  - class_idx is held stable until class_ready is sampled high.
  - On acceptance, go to LOAD.
- Buffer and cmp_arr:
  - Written only in LOAD.
  - cmp_arr is a direct view of the buffer, so it is stable through CLR, RUN and OUT.
- score_ready is 0 in CLR, RUN and OUT. No new frame is accepted until the current result is taken.
- cmp_done is ignored outside RUN.

## Timing
- Reset values (while reset is low, sampled on the edge):
  - State LOAD, cnt=0, buffer all zero.
  - score_ready=1, cmp_reset=1, cmp_enable=0, class_valid=0, class_idx=0, busy=0, err=0.
  - cmp_reset is registered; it drops on the first edge after reset goes high.
- Latency, with the final beat accepted at edge T:
  - CLR during cycle T+1; RUN from T+2.
  - cmp_done sampled at edge D gives class_valid=1 from D+1.
- A reset asserted in any state, including mid-RUN or OUT, returns everything to the reset values on the next edge. No partial result is emitted.
- Result handshake at edge A with class_valid && class_ready: LOAD (score_ready=1) from A+1. The earliest next-frame beat is accepted at A+1.
- score_last together with a full count on the same beat: normal completion, no error.

## Configuration
- FC_ARGMAX_TIMEOUT_EN, defined:
  - A cycle counter runs in RUN and clears on entry to RUN.
  - If it reaches TIMEOUT_CYCLES without cmp_done, set err[1], load class_idx with all ones (4'hF), and go to OUT.
  - A cmp_done on the same cycle as the limit wins: normal result, no error.
- FC_ARGMAX_TIMEOUT_EN, undefined: no counter; RUN waits indefinitely; err[1] is tied to 0.

## Test plan
- Frame 0x0800,0x0000,0x0001,0x0002,0x0004,0x0008,0x0010,0x0020,0x0040,0x0080 with last on beat 9, class_ready=1 -> one cycle of cmp_reset, then cmp_enable; class_idx=0 with one class_valid pulse; err=0.
- Frame with 0x7FFF at index 9, all others 0x0001, class_ready held low for 5 cycles after class_valid -> class_valid and class_idx=9 held stable 5 cycles; score_ready=0 throughout; LOAD follows the accept.
- score_last on beat 3 -> err[0]=1, cnt resets; a following correct frame with max 0x0100 at index 4 -> class_idx=4.
- Back-to-back frames with score_valid always high -> second frame's first beat accepted the cycle after the first result's handshake; both indices correct.
- Reset pulled low during RUN -> next edge: cmp_enable=0, cmp_reset=1, class_valid=0, score_ready=1; no result is emitted for the aborted frame.
- With FC_ARGMAX_TIMEOUT_EN and cmp_done tied 0 -> after 64 RUN cycles class_idx=4'hF, class_valid=1, err[1]=1. Without the macro -> remains in RUN with busy=1 indefinitely.

Source files
------------

// File: rtl/fc_argmax_ctrl.sv
// Argmax sequencer: buffers one frame of class scores, then pulses the comparator clear,
// runs it to completion and returns the winning index. Optional watchdog: FC_ARGMAX_TIMEOUT_EN.
module fc_argmax_ctrl #(
  parameter int DATA_W         = 16,
  parameter int NUM_CLASSES    = 10,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          score_valid,
  input  logic [DATA_W-1:0]             score_data,
  input  logic                          score_last,
  output logic                          score_ready,
  output logic [NUM_CLASSES*DATA_W-1:0] cmp_arr,
  output logic                          cmp_reset,
  output logic                          cmp_enable,
  input  logic                          cmp_done,
  input  logic [IDX_W-1:0]              cmp_result,
  output logic                          class_valid,
  output logic [IDX_W-1:0]              class_idx,
  input  logic                          class_ready,
  output logic                          busy,
  output logic [1:0]                    err
);

  typedef enum logic [1:0] {LOAD, CLR, RUN, OUT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         cnt;
  logic signed [DATA_W-1:0] sbuf [NUM_CLASSES];
  logic                     accept, final_beat, early_last, timeout;

  if (((2 ** IDX_W) < NUM_CLASSES + 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("fc_argmax_ctrl: IDX_W too narrow or TIMEOUT_CYCLES < 1");
  end

  assign accept     = score_valid && score_ready;
  assign final_beat = accept && (cnt == LAST_IDX);
  assign early_last = accept && score_last && (cnt != LAST_IDX);

`ifdef FC_ARGMAX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  // Held at zero outside RUN, so every entry into RUN starts a fresh count.
  always_ff @(posedge clk) begin
    if (!reset || state != RUN) tcnt <= '0;
    else                        tcnt <= tcnt + 1'b1;
  end

  assign timeout = (state == RUN) && !cmp_done && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      cnt       <= '0;
      cmp_reset <= 1'b1;
      class_idx <= '0;
      err       <= '0;
    end else begin
      state     <= state_nxt;
      cmp_reset <= (state_nxt == CLR);
      if (accept) cnt <= (score_last || cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      if ((final_beat && !score_last) || early_last) err[0] <= 1'b1;
      // A done on the watchdog's last cycle takes priority over the timeout.
      if (state == RUN) begin
        if (cmp_done) class_idx <= cmp_result;
        else if (timeout) begin
          class_idx <= '1;
          err[1]    <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) sbuf[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CLASSES; i++)
        if (cnt == IDX_W'(i)) sbuf[i] <= $signed(score_data);
    end
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_arr
    assign cmp_arr[DATA_W*g +: DATA_W] = sbuf[g];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (final_beat) state_nxt = CLR;
      CLR:     state_nxt = RUN;
      RUN:     if (cmp_done || timeout) state_nxt = OUT;
      OUT:     if (class_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    score_ready = 1'b0;
    cmp_enable  = 1'b0;
    class_valid = 1'b0;
    busy        = 1'b1;
    case (state)
      LOAD: begin
        score_ready = 1'b1;
        busy        = 1'b0;
      end
      RUN:     cmp_enable  = 1'b1;
      OUT:     class_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fc_argmax_ctrl.sv
// Randomised bench for fc_argmax_ctrl; the bench plays the comparator using its own argmax model.
module tb_fc_argmax_ctrl;
  localparam int DATA_W = 16;
  localparam int NC     = 10;
  localparam int IDX_W  = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 score_valid, score_last, score_ready;
  logic [DATA_W-1:0]    score_data;
  logic [NC*DATA_W-1:0] cmp_arr;
  logic                 cmp_reset, cmp_enable, cmp_done;
  logic [IDX_W-1:0]     cmp_result, class_idx;
  logic                 class_valid, class_ready, busy;
  logic [1:0]           err;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] frame [NC];
  logic [1:0]        exp_err;

  fc_argmax_ctrl #(.DATA_W(DATA_W), .NUM_CLASSES(NC), .IDX_W(IDX_W), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .score_valid(score_valid), .score_data(score_data),
    .score_last(score_last), .score_ready(score_ready), .cmp_arr(cmp_arr),
    .cmp_reset(cmp_reset), .cmp_enable(cmp_enable), .cmp_done(cmp_done),
    .cmp_result(cmp_result), .class_valid(class_valid), .class_idx(class_idx),
    .class_ready(class_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Signed argmax, lowest index wins ties.
  function automatic logic [IDX_W-1:0] ref_argmax();
    int best = 0;
    for (int i = 1; i < NC; i++)
      if ($signed(frame[i]) > $signed(frame[best])) best = i;
    return IDX_W'(best);
  endfunction

  function automatic logic [NC*DATA_W-1:0] ref_arr();
    logic [NC*DATA_W-1:0] a;
    for (int i = 0; i < NC; i++) a[DATA_W*i +: DATA_W] = frame[i];
    return a;
  endfunction

  task automatic do_reset;
    reset = 1'b0; score_valid = 1'b0; score_last = 1'b0; score_data = '0;
    cmp_done = 1'b0; cmp_result = '0; class_ready = 1'b0;
    tick; tick;
    reset = 1'b1;
    exp_err = 2'b00;
  endtask

  // Streams frame[] ending at edge T; returns at T+2 (first RUN cycle).
  task automatic load_frame(input bit last_on_final, input bit keep_valid);
    for (int i = 0; i < NC; i++) begin
      score_valid = 1'b1; score_data = frame[i];
      score_last  = (i == NC - 1) ? last_on_final : 1'b0;
      checks++;
      if (score_ready !== 1'b1) begin failures++; $display("FAIL load_ready beat %0d: got %b want 1", i, score_ready); end
      tick;
    end
    score_valid = keep_valid; score_data = DATA_W'($urandom); score_last = 1'($urandom);
    checks++;
    if ({cmp_reset, cmp_enable, score_ready, busy} !== 4'b1001) begin
      failures++; $display("FAIL clr_ctrl: got %b want 1001", {cmp_reset, cmp_enable, score_ready, busy});
    end
    checks++;
    if (cmp_arr !== ref_arr()) begin failures++; $display("FAIL cmp_arr: got %h want %h", cmp_arr, ref_arr()); end
    tick;
    score_data = DATA_W'($urandom);
    checks++;
    if ({cmp_reset, cmp_enable, score_ready, busy} !== 4'b0101) begin
      failures++; $display("FAIL run_ctrl: got %b want 0101", {cmp_reset, cmp_enable, score_ready, busy});
    end
  endtask

  // Plays the comparator from the RUN state and then takes the result.
  task automatic finish_frame(input int done_delay, input int ready_delay);
    logic [IDX_W-1:0] want;
    want = ref_argmax();
    for (int k = 0; k < done_delay; k++) begin
      tick;
      score_data = DATA_W'($urandom);
      checks++;
      if ({cmp_enable, class_valid} !== 2'b10) begin
        failures++; $display("FAIL run_wait: got %b want 10", {cmp_enable, class_valid});
      end
    end
    cmp_done = 1'b1; cmp_result = want;
    tick;
    cmp_done = 1'b0; cmp_result = IDX_W'($urandom);
    class_ready = (ready_delay == 0);
    checks++;
    if ({class_valid, cmp_enable, class_idx} !== {2'b10, want}) begin
      failures++; $display("FAIL result: got %b want %b", {class_valid, cmp_enable, class_idx}, {2'b10, want});
    end
    for (int k = 0; k < ready_delay; k++) begin
      tick;
      score_data = DATA_W'($urandom);
      checks++;
      if ({class_valid, score_ready, class_idx} !== {2'b10, want} || cmp_arr !== ref_arr()) begin
        failures++; $display("FAIL hold: got %b want %b", {class_valid, score_ready, class_idx}, {2'b10, want});
      end
    end
    class_ready = 1'b1;
    tick;
    class_ready = 1'b0;
    checks++;
    if ({class_valid, score_ready, busy, err} !== {3'b010, exp_err}) begin
      failures++; $display("FAIL accept: got %b want %b", {class_valid, score_ready, busy, err}, {3'b010, exp_err});
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; score_valid = 1'b0; score_last = 1'b0; score_data = '0;
    cmp_done = 1'b0; cmp_result = '0; class_ready = 1'b0;
    tick; tick;
    checks++;
    if ({score_ready, cmp_reset, cmp_enable, class_valid, busy, err, class_idx} !== {5'b11000, 2'b00, 4'h0}
        || cmp_arr !== '0) begin
      failures++; $display("FAIL reset_vals: got %b", {score_ready, cmp_reset, cmp_enable, class_valid, busy, err, class_idx});
    end
    reset = 1'b1; exp_err = 2'b00;
    tick;
    checks++;
    if ({cmp_reset, score_ready} !== 2'b01) begin failures++; $display("FAIL reset_release: got %b want 01", {cmp_reset, score_ready}); end
  endtask

  task automatic test_basic;
    frame[0] = 16'h0800;
    for (int i = 1; i < NC; i++) frame[i] = (i == 1) ? 16'h0000 : DATA_W'(1 << (i - 2));
    load_frame(1'b1, 1'b0);
    finish_frame(2, 0);
  endtask

  task automatic test_hold;
    for (int i = 0; i < NC; i++) frame[i] = (i == 9) ? 16'h7FFF : 16'h0001;
    load_frame(1'b1, 1'b0);
    finish_frame(0, 5);
  endtask

  task automatic test_short_frame;
    for (int i = 0; i < 4; i++) begin
      score_valid = 1'b1; score_data = 16'h0050; score_last = (i == 3);
      tick;
    end
    score_valid = 1'b0; score_last = 1'b0;
    exp_err = 2'b01;
    checks++;
    if ({err, score_ready, busy, cmp_reset} !== 5'b01100) begin
      failures++; $display("FAIL short_frame: got %b want 01100", {err, score_ready, busy, cmp_reset});
    end
    for (int i = 0; i < NC; i++) frame[i] = (i == 4) ? 16'h0100 : DATA_W'(i);
    load_frame(1'b1, 1'b0);
    finish_frame(1, 1);
  endtask

  task automatic test_no_last;
    do_reset;
    for (int i = 0; i < NC; i++) frame[i] = DATA_W'($urandom);
    load_frame(1'b0, 1'b0);
    exp_err = 2'b01;
    checks++;
    if (err !== 2'b01) begin failures++; $display("FAIL no_last_err: got %b want 01", err); end
    finish_frame(0, 0);
  endtask

  task automatic test_back_to_back;
    do_reset;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NC; i++) frame[i] = DATA_W'($urandom_range(0, 16'h7FFF));
      frame[$urandom_range(0, NC - 1)] = 16'h7FFF;
      load_frame(1'b1, 1'b1);
      finish_frame($urandom_range(0, 3), $urandom_range(0, 2));
    end
    score_valid = 1'b0;
  endtask

  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NC; i++) frame[i] = DATA_W'($urandom);
      load_frame(1'b1, 1'($urandom));
      finish_frame($urandom_range(0, 6), $urandom_range(0, 4));
      score_valid = 1'b0;
    end
  endtask

  task automatic test_reset_in_run;
    for (int i = 0; i < NC; i++) frame[i] = DATA_W'($urandom);
    load_frame(1'b1, 1'b0);
    tick;
    reset = 1'b0; cmp_done = 1'b1; cmp_result = 4'h3;
    tick;
    checks++;
    if ({cmp_enable, cmp_reset, class_valid, score_ready, busy, err, class_idx} !== {5'b01010, 2'b00, 4'h0}) begin
      failures++; $display("FAIL reset_run: got %b", {cmp_enable, cmp_reset, class_valid, score_ready, busy, err, class_idx});
    end
    reset = 1'b1; exp_err = 2'b00;
    tick; tick;
    cmp_done = 1'b0;
    checks++;
    if ({class_valid, score_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL reset_run_after: got %b want 010", {class_valid, score_ready, busy});
    end
  endtask

  task automatic test_no_done;
    for (int i = 0; i < NC; i++) frame[i] = DATA_W'($urandom);
    load_frame(1'b1, 1'b0);
`ifdef FC_ARGMAX_TIMEOUT_EN
    repeat (63) tick;
    checks++;
    if ({cmp_enable, class_valid} !== 2'b10) begin failures++; $display("FAIL timeout_early: got %b want 10", {cmp_enable, class_valid}); end
    tick;
    checks++;
    if ({class_valid, class_idx, err[1]} !== {1'b1, 4'hF, 1'b1}) begin
      failures++; $display("FAIL timeout: got %b want 111111", {class_valid, class_idx, err[1]});
    end
    class_ready = 1'b1; tick; class_ready = 1'b0;
`else
    repeat (100) tick;
    checks++;
    if ({busy, cmp_enable, class_valid, err[1]} !== 4'b1100) begin
      failures++; $display("FAIL no_done: got %b want 1100", {busy, cmp_enable, class_valid, err[1]});
    end
`endif
    do_reset;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_short_frame;
    test_no_last;
    test_back_to_back;
    test_random;
    test_reset_in_run;
    test_no_done;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
